// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the divide_unit datapath.
// The divide-by-zero trap is selected in divide_unit by DIV_ZERO_TRAP_EN.
package div_pkg;

    localparam int WIDTH     = 32;
    localparam int DIV_ITERS = WIDTH;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

    // Magnitude of a two's complement value; unsigned operands pass through.
    // The most negative value maps to itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);

    logic [W:0] w_shift;
    logic [W:0] w_trial;

    // The trial runs on W+1 bits so the borrow lands in the top bit.
    assign w_shift = {i_rem, i_quo[W-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};

    assign o_quo = {i_quo[W-2:0], ~w_trial[W]};
    assign o_rem = w_trial[W] ? w_shift[W-1:0] : w_trial[W-1:0];

endmodule

// File: rtl/divide_unit.sv
// Multicycle DIV/DIVU unit: Lo = quotient, Hi = remainder, EndDivFlag pulses on completion.
// Define DIV_ZERO_TRAP_EN to short-circuit divide-by-zero straight from PREP to DONE.
module divide_unit
    import div_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             EndDivFlag,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    div_state_t       r_state;
    logic             r_busy;
    logic             r_end;
    logic             r_divzero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic             r_bzero;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_quo;

    div_step #(.W(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem),
        .o_quo     (w_quo)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_end     <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_end <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_state <= PREP;
                        r_busy  <= 1'b1;
                    end
                end
                PREP: begin
                    r_state <= ITER;
`ifdef DIV_ZERO_TRAP_EN
                    if (r_bzero) begin
                        r_state   <= DONE;
                        r_end     <= 1'b1;
                        r_divzero <= 1'b1;
                    end
`endif
                end
                ITER: begin
                    if (r_cnt == '0) r_state <= FIX;
                end
                FIX: begin
                    r_state   <= DONE;
                    r_end     <= 1'b1;
                    r_divzero <= r_bzero;
                    // Division by zero reports the raw dividend, bypassing the sign fix-up.
                    if (r_bzero) begin
                        r_lo <= '1;
                        r_hi <= r_a;
                    end else begin
                        r_lo <= r_qneg ? -r_quo : r_quo;
                        r_hi <= r_rneg ? -r_rem : r_rem;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; every operation reloads them before use.
    always_ff @(posedge Clk) begin
        case (r_state)
            IDLE: begin
                if (Reset && Start) begin
                    r_a      <= A;
                    r_b      <= B;
                    r_signed <= Signed;
                    r_bzero  <= (B == '0);
                end
            end
            PREP: begin
                r_rem  <= '0;
                r_quo  <= abs_val(r_a, r_signed);
                r_div  <= abs_val(r_b, r_signed);
                r_qneg <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                r_rneg <= r_signed & r_a[WIDTH-1];
                r_cnt  <= CNT_W'(DIV_ITERS - 1);
            end
            ITER: begin
                r_rem <= w_rem;
                r_quo <= w_quo;
                r_cnt <= r_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    assign Busy       = r_busy;
    assign EndDivFlag = r_end;
    assign DivZero    = r_divzero;
    assign Hi         = r_hi;
    assign Lo         = r_lo;

endmodule

// File: tb/tb_divide_unit.sv
// Self-checking bench for divide_unit: a cycle-timeline reference model compared every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_divide_unit;

`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int LAT = 34;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Signed = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic        EndDivFlag;
    logic        DivZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    divide_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Signed     (Signed),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .EndDivFlag (EndDivFlag),
        .DivZero    (DivZero),
        .Hi         (Hi),
        .Lo         (Lo)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: 64-bit signed division truncates toward zero and gives the
    // remainder the dividend's sign; the widening also makes MIN/-1 wrap naturally.
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] lo, output logic [31:0] hi);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Timeline model: an accepted Start completes a fixed number of edges later.
    bit          m_valid = 1'b0;
    bit          m_pending = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_end = 1'b0;
    bit          m_dz = 1'b0;
    bit          p_zero;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    longint      m_edge = 0;
    longint      m_done_edge = 0;
    longint      m_free_edge = 0;

    always @(posedge Clk) begin
        m_edge++;
        m_end = 1'b0;
        if (!Reset) begin
            m_valid     = 1'b1;
            m_pending   = 1'b0;
            m_hi        = '0;
            m_lo        = '0;
            m_dz        = 1'b0;
            m_free_edge = m_edge + 1;
        end else if (m_pending && m_edge == m_done_edge) begin
            m_end       = 1'b1;
            m_pending   = 1'b0;
            m_dz        = p_zero;
            m_free_edge = m_edge + 1;
            if (!(TRAP && p_zero)) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (!m_pending && m_edge >= m_free_edge && Start) begin
            ref_div(Signed, A, B, p_lo, p_hi);
            p_zero      = (B == 32'd0);
            m_pending   = 1'b1;
            m_done_edge = m_edge + ((TRAP && p_zero) ? 1 : LAT);
        end
        m_busy = m_pending || m_end;
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            check("cyc_busy", 64'(Busy), 64'(m_busy));
            check("cyc_end", 64'(EndDivFlag), 64'(m_end));
            check("cyc_divzero", 64'(DivZero), 64'(m_dz));
            check("cyc_hi", 64'(Hi), 64'(m_hi));
            check("cyc_lo", 64'(Lo), 64'(m_lo));
        end
    end

    // Issue one operation from IDLE, measure edges from capture to EndDivFlag,
    // check literal results, then let the unit return to IDLE.
    task automatic run_op(input string nm, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo,
                          input logic [31:0] ehi, input bit edz, input int elat);
        int n;
        Signed = s;
        A      = a;
        B      = b;
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        n = 0;
        while (!EndDivFlag && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'(elat));
        check({nm, "_lo"}, 64'(Lo), 64'(elo));
        check({nm, "_hi"}, 64'(Hi), 64'(ehi));
        check({nm, "_divzero"}, 64'(DivZero), 64'(edz));
        @(posedge Clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ends;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_end", 64'(EndDivFlag), 64'd0);
        check("rst_divzero", 64'(DivZero), 64'd0);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        @(posedge Clk); #1;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
        run_op("divu_max_3", 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0, 1'b0, 34);
        run_op("divu_big", 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 1'b0, 34);
`ifdef DIV_ZERO_TRAP_EN
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1, 1);
        run_op("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1, 1);
`else
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 34);
        run_op("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 34);
`endif
        run_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);

        // Abort: start 100/7, a stray 9/3 Start at edge 5, reset at edge 10.
        Signed = 1'b0;
        A      = 32'd100;
        B      = 32'd7;
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        A     = 32'd9;
        B     = 32'd3;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("abort_busy_mid", 64'(Busy), 64'd1);
        repeat (4) @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_end", 64'(EndDivFlag), 64'd0);
        check("abort_divzero", 64'(DivZero), 64'd0);
        check("abort_hi", 64'(Hi), 64'd0);
        check("abort_lo", 64'(Lo), 64'd0);
        ends = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (EndDivFlag) ends++;
        end
        check("abort_no_end", 64'(ends), 64'd0);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

        repeat (3) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
